// File: rtl/spi_reg_bridge.sv
// SPI-to-register bridge: a 16 x 8-bit register file that an SPI frame can write or read,
// plus a fabric-side host port. Define SPI_REG_BRIDGE_ID_EN to make 0xF a constant ID (0xA5).
module spi_reg_bridge (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       spi_csn,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  input  logic [3:0] host_addr,
  input  logic [7:0] host_wdata,
  input  logic       host_we,
  output logic [7:0] host_rdata,
  output logic       wr_pulse,
  output logic [3:0] wr_addr,
  output logic       busy
);

`ifdef SPI_REG_BRIDGE_ID_EN
  localparam bit IdEn = 1'b1;
`else
  localparam bit IdEn = 1'b0;
`endif
  localparam logic [3:0] IdAddr  = 4'hF;
  localparam logic [7:0] IdValue = 8'hA5;

  typedef enum logic [1:0] {StIdle, StCmd, StWrite, StRead} state_e;

  state_e     state_q, state_d;
  logic       csn_q;
  logic [6:0] addr_q, addr_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_q, tx_load_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] host_rdata_q, host_rdata_d;

  logic [6:0] spi_rd_addr;
  logic [7:0] spi_rdata;
  logic       spi_wr_ok;

  // The command byte supplies the read address directly; later bytes pre-increment.
  assign spi_rd_addr = (state_q == StCmd) ? rx_byte[6:0] : addr_q + 7'd1;
  assign spi_wr_ok   = (addr_q[6:4] == 3'd0) && !(IdEn && (addr_q[3:0] == IdAddr));

  always_comb begin
    spi_rdata = 8'h00;
    if (spi_rd_addr[6:4] == 3'd0) begin
      if (IdEn && (spi_rd_addr[3:0] == IdAddr)) spi_rdata = IdValue;
      else                                      spi_rdata = regs_q[spi_rd_addr[3:0]];
    end
  end

  always_comb begin
    if (IdEn && (host_addr == IdAddr)) host_rdata_d = IdValue;
    else                               host_rdata_d = regs_q[host_addr];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_byte_d  = tx_byte_q;
    tx_load_d  = 1'b0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    regs_d     = regs_q;

    // Host write first so a same-address SPI write below overrides it.
    if (host_we && !(IdEn && (host_addr == IdAddr))) regs_d[host_addr] = host_wdata;

    case (state_q)
      StIdle: begin
        if (csn_q && !spi_csn) state_d = StCmd;
      end
      StCmd: begin
        if (spi_csn) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          addr_d = rx_byte[6:0];
          if (rx_byte[7]) begin
            state_d   = StRead;
            tx_byte_d = spi_rdata;
            tx_load_d = 1'b1;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        if (spi_csn) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          if (spi_wr_ok) begin
            regs_d[addr_q[3:0]] = rx_byte;
            wr_pulse_d          = 1'b1;
            wr_addr_d           = addr_q[3:0];
          end
          addr_d = addr_q + 7'd1;
        end
      end
      StRead: begin
        if (spi_csn) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          addr_d    = spi_rd_addr;
          tx_byte_d = spi_rdata;
          tx_load_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      csn_q        <= 1'b0;
      addr_q       <= 7'd0;
      tx_byte_q    <= 8'h00;
      tx_load_q    <= 1'b0;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= 4'h0;
      host_rdata_q <= 8'h00;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      csn_q        <= spi_csn;
      addr_q       <= addr_d;
      tx_byte_q    <= tx_byte_d;
      tx_load_q    <= tx_load_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      host_rdata_q <= host_rdata_d;
      regs_q       <= regs_d;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_load    = tx_load_q;
  assign wr_pulse   = wr_pulse_q;
  assign wr_addr    = wr_addr_q;
  assign host_rdata = host_rdata_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge; honours SPI_REG_BRIDGE_ID_EN for the 0xF cases.
module tb_spi_reg_bridge;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       spi_csn;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_we;
  logic [7:0] host_rdata;
  logic       wr_pulse;
  logic [3:0] wr_addr;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef SPI_REG_BRIDGE_ID_EN
  localparam logic [7:0] RegFExp   = 8'hA5;
  localparam logic       RegFPulse = 1'b0;
`else
  localparam logic [7:0] RegFExp   = 8'h3C;
  localparam logic       RegFPulse = 1'b1;
`endif

  spi_reg_bridge dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .spi_csn    (spi_csn),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_rdata (host_rdata),
    .wr_pulse   (wr_pulse),
    .wr_addr    (wr_addr),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic host_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    host_addr = a;
    tick();
    check_eq(tag, host_rdata, exp);
  endtask

  task automatic csn_low();
    spi_csn = 1'b0;
    tick();
  endtask

  task automatic csn_high();
    spi_csn = 1'b1;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    spi_csn    = 1'b1;
    rx_byte    = 8'h00;
    rx_valid   = 1'b0;
    host_addr  = 4'h0;
    host_wdata = 8'h00;
    host_we    = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tx_byte", tx_byte, 8'h00);
    check_eq("rst_tx_load", tx_load, 0);
    check_eq("rst_wr_pulse", wr_pulse, 0);
    check_eq("rst_wr_addr", wr_addr, 4'h0);
    check_eq("rst_host_rdata", host_rdata, 8'h00);
    rst = 1'b0;
    tick();

    // Basic write frame
    csn_low();
    check_eq("w_busy", busy, 1);
    send(8'h03);
    check_eq("w_cmd_nopulse", wr_pulse, 0);
    send(8'h11);
    check_eq("w_pulse0", wr_pulse, 1);
    check_eq("w_addr0", wr_addr, 4'h3);
    send(8'h22);
    check_eq("w_pulse1", wr_pulse, 1);
    check_eq("w_addr1", wr_addr, 4'h4);
    csn_high();
    check_eq("w_idle_busy", busy, 0);
    check_eq("w_pulse_end", wr_pulse, 0);
    host_chk("reg3", 4'h3, 8'h11);
    host_chk("reg4", 4'h4, 8'h22);

    // Read frame after host writes
    host_wr(4'h5, 8'h5A);
    host_wr(4'h6, 8'h66);
    host_wr(4'h7, 8'h77);
    host_chk("reg5_host", 4'h5, 8'h5A);
    csn_low();
    send(8'h85);
    check_eq("r_load0", tx_load, 1);
    check_eq("r_byte0", tx_byte, 8'h5A);
    tick();
    check_eq("r_load_gap", tx_load, 0);
    check_eq("r_hold", tx_byte, 8'h5A);
    send(8'h00);
    check_eq("r_load1", tx_load, 1);
    check_eq("r_byte1", tx_byte, 8'h66);
    send(8'h00);
    check_eq("r_load2", tx_load, 1);
    check_eq("r_byte2", tx_byte, 8'h77);
    csn_high();
    check_eq("r_idle_busy", busy, 0);

    // Write wrap from 0x7F
    csn_low();
    send(8'h7F);
    send(8'hAA);
    check_eq("wrap_discard", wr_pulse, 0);
    send(8'hBB);
    check_eq("wrap_pulse", wr_pulse, 1);
    check_eq("wrap_addr", wr_addr, 4'h0);
    csn_high();
    host_chk("reg0_wrap", 4'h0, 8'hBB);

    // Read wrap from 0x7F
    csn_low();
    send(8'hFF);
    check_eq("rwrap_oob", tx_byte, 8'h00);
    send(8'h00);
    check_eq("rwrap_load", tx_load, 1);
    check_eq("rwrap_byte", tx_byte, 8'hBB);
    csn_high();

    // csn rises together with a data byte
    csn_low();
    send(8'h08);
    spi_csn  = 1'b1;
    rx_byte  = 8'h99;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_eq("abort_pulse", wr_pulse, 0);
    check_eq("abort_busy", busy, 0);
    host_chk("reg8_abort", 4'h8, 8'h00);

    // Reset in the middle of a write frame
    csn_low();
    send(8'h09);
    send(8'h12);
    check_eq("rstm_pulse", wr_pulse, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(8'h34);
    send(8'h56);
    check_eq("rstm_nopulse", wr_pulse, 0);
    check_eq("rstm_busy", busy, 0);
    host_chk("reg9_cleared", 4'h9, 8'h00);
    host_chk("reg10_clean", 4'hA, 8'h00);
    csn_high();
    csn_low();
    check_eq("rstm_new_busy", busy, 1);
    send(8'h0A);
    send(8'h77);
    check_eq("rstm_new_pulse", wr_pulse, 1);
    check_eq("rstm_new_addr", wr_addr, 4'hA);
    csn_high();
    host_chk("reg10_new", 4'hA, 8'h77);

    // Same-cycle host and SPI writes
    csn_low();
    send(8'h02);
    host_addr  = 4'h2;
    host_wdata = 8'h44;
    host_we    = 1'b1;
    send(8'h33);
    host_addr  = 4'h1;
    send(8'h55);
    host_we    = 1'b0;
    csn_high();
    host_chk("coll_same", 4'h2, 8'h33);
    host_chk("coll_host", 4'h1, 8'h44);
    host_chk("coll_spi", 4'h3, 8'h55);

    // Register 0xF
    host_wr(4'hF, 8'h00);
    csn_low();
    send(8'h0F);
    send(8'h3C);
    check_eq("regf_pulse", wr_pulse, RegFPulse);
    csn_high();
    host_chk("regf_host", 4'hF, RegFExp);
    csn_low();
    send(8'h8F);
    check_eq("regf_spi", tx_byte, RegFExp);
    csn_high();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
